// File: rtl/writeback_scheduler.sv
// Shares one register-file write port among scalar ALU, vector ALU and memory
// results using round-robin arbitration. Keeps a per-register busy scoreboard for decode stalls.
module writeback_scheduler #(
  parameter int SCALAR_DATA_WIDTH = 48,
  parameter int VECTOR_DATA_WIDTH = 8,
  parameter int VECTOR_SIZE       = 6,
  parameter int ADDRESS_WIDTH     = 4
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [2:0]                                       reqValid,
  output logic [2:0]                                       reqReady,
  input  logic [2:0]                                       reqIsVector,
  input  logic [2:0][ADDRESS_WIDTH-1:0]                    reqAddress,
  input  logic [2:0][SCALAR_DATA_WIDTH-1:0]                reqScalarData,
  input  logic [2:0][VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0] reqVectorData,
  input  logic                                             issueValid,
  input  logic                                             issueIsVector,
  input  logic [ADDRESS_WIDTH-1:0]                         issueAddress,
  input  logic                                             check1IsVector,
  input  logic                                             check2IsVector,
  input  logic                                             checkDestIsVector,
  input  logic [ADDRESS_WIDTH-1:0]                         check1Address,
  input  logic [ADDRESS_WIDTH-1:0]                         check2Address,
  input  logic [ADDRESS_WIDTH-1:0]                         checkDestAddress,
  output logic                                             stall,
  output logic                                             writeEnableScalar,
  output logic                                             writeEnableVector,
  output logic [ADDRESS_WIDTH-1:0]                         writeAddress,
  output logic [SCALAR_DATA_WIDTH-1:0]                     writeScalarData,
  output logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]    writeVectorData
);

  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

  logic [1:0]          last_reg;
  logic [1:0]          start_idx;
  logic [1:0]          grant_idx;
  logic                grant_any;
  logic                transfer;
  logic [NUM_REGS-1:0] busy_s_reg;
  logic [NUM_REGS-1:0] busy_v_reg;
  logic [NUM_REGS-1:0] busy_s_next;
  logic [NUM_REGS-1:0] busy_v_next;

  function automatic logic [1:0] rr_index(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  assign start_idx = (last_reg == 2'd2) ? 2'd0 : last_reg + 2'd1;

  // Scan from farthest to nearest offset so the nearest valid requester wins.
  always_comb begin
    grant_idx = 2'd0;
    grant_any = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (reqValid[rr_index(start_idx, 2'(k))]) begin
        grant_idx = rr_index(start_idx, 2'(k));
        grant_any = 1'b1;
      end
    end
  end

  assign transfer = reset & grant_any;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ready
      assign reqReady[gi] = transfer & (grant_idx == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_reg          <= 2'd2;
      writeEnableScalar <= 1'b0;
      writeEnableVector <= 1'b0;
      writeAddress      <= '0;
      writeScalarData   <= '0;
      writeVectorData   <= '0;
    end else begin
      writeEnableScalar <= transfer & ~reqIsVector[grant_idx];
      writeEnableVector <= transfer & reqIsVector[grant_idx];
      if (transfer) begin
        last_reg        <= grant_idx;
        writeAddress    <= reqAddress[grant_idx];
        writeScalarData <= reqScalarData[grant_idx];
        writeVectorData <= reqVectorData[grant_idx];
      end
    end
  end

  // Clear for the committing write is applied first so a same-cycle issue keeps the bit set.
  always_comb begin
    busy_s_next = busy_s_reg;
    busy_v_next = busy_v_reg;
    if (writeEnableScalar) busy_s_next[writeAddress] = 1'b0;
    if (writeEnableVector) busy_v_next[writeAddress] = 1'b0;
    if (issueValid) begin
      if (issueIsVector) busy_v_next[issueAddress] = 1'b1;
      else               busy_s_next[issueAddress] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_s_reg <= '0;
      busy_v_reg <= '0;
    end else begin
      busy_s_reg <= busy_s_next;
      busy_v_reg <= busy_v_next;
    end
  end

  function automatic logic busy_lookup(input logic is_vec, input logic [ADDRESS_WIDTH-1:0] addr,
                                       input logic [NUM_REGS-1:0] bs, input logic [NUM_REGS-1:0] bv);
    return is_vec ? bv[addr] : bs[addr];
  endfunction

  assign stall = reset & (busy_lookup(check1IsVector, check1Address, busy_s_reg, busy_v_reg)
                        | busy_lookup(check2IsVector, check2Address, busy_s_reg, busy_v_reg)
                        | busy_lookup(checkDestIsVector, checkDestAddress, busy_s_reg, busy_v_reg));

endmodule

// File: tb/tb_writeback_scheduler.sv
// Directed bench for writeback_scheduler: arbitration order, write stage, scoreboard and reset.
module tb_writeback_scheduler;

  logic                clock = 1'b0;
  logic                reset;
  logic [2:0]          reqValid;
  logic [2:0]          reqReady;
  logic [2:0]          reqIsVector;
  logic [2:0][3:0]     reqAddress;
  logic [2:0][47:0]    reqScalarData;
  logic [2:0][5:0][7:0] reqVectorData;
  logic                issueValid, issueIsVector;
  logic [3:0]          issueAddress;
  logic                check1IsVector, check2IsVector, checkDestIsVector;
  logic [3:0]          check1Address, check2Address, checkDestAddress;
  logic                stall;
  logic                writeEnableScalar, writeEnableVector;
  logic [3:0]          writeAddress;
  logic [47:0]         writeScalarData;
  logic [5:0][7:0]     writeVectorData;

  int total = 0;
  int bad = 0;

  writeback_scheduler dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqIsVector(reqIsVector),
    .reqAddress(reqAddress), .reqScalarData(reqScalarData), .reqVectorData(reqVectorData),
    .issueValid(issueValid), .issueIsVector(issueIsVector), .issueAddress(issueAddress),
    .check1IsVector(check1IsVector), .check2IsVector(check2IsVector),
    .checkDestIsVector(checkDestIsVector),
    .check1Address(check1Address), .check2Address(check2Address),
    .checkDestAddress(checkDestAddress),
    .stall(stall),
    .writeEnableScalar(writeEnableScalar), .writeEnableVector(writeEnableVector),
    .writeAddress(writeAddress), .writeScalarData(writeScalarData),
    .writeVectorData(writeVectorData)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected write-stage outputs after a grant to requester g (round-robin phase).
  task automatic check_write(input string tag, input int g);
    logic [3:0] exp_addr [3];
    exp_addr[0] = 4'd8; exp_addr[1] = 4'd9; exp_addr[2] = 4'd10;
    check({tag, " enS"}, 64'(writeEnableScalar), (g == 1) ? 64'd0 : 64'd1);
    check({tag, " enV"}, 64'(writeEnableVector), (g == 1) ? 64'd1 : 64'd0);
    check({tag, " addr"}, 64'(writeAddress), 64'(exp_addr[g]));
    if (g == 1) check({tag, " vdata"}, 64'(writeVectorData), 64'h0000_1112_1314_1516);
    else        check({tag, " sdata"}, 64'(writeScalarData), (g == 0) ? 64'h0000_AAAA_0000_0001
                                                                       : 64'h0000_CCCC_0000_0003);
  endtask

  initial begin
    reset = 1'b0;
    reqValid = 3'b111;
    reqIsVector = 3'b010;
    reqAddress[0] = 4'd8; reqAddress[1] = 4'd9; reqAddress[2] = 4'd10;
    reqScalarData[0] = 48'hAAAA_0000_0001;
    reqScalarData[1] = 48'hBBBB_0000_0002;
    reqScalarData[2] = 48'hCCCC_0000_0003;
    reqVectorData[0] = 48'h0;
    reqVectorData[1] = 48'h1112_1314_1516;
    reqVectorData[2] = 48'h0;
    issueValid = 1'b0; issueIsVector = 1'b0; issueAddress = 4'd0;
    check1IsVector = 1'b0; check2IsVector = 1'b0; checkDestIsVector = 1'b0;
    check1Address = 4'd0; check2Address = 4'd0; checkDestAddress = 4'd0;

    // Reset held for two edges with every producer requesting.
    step();
    step();
    check("rst ready", 64'(reqReady), 64'd0);
    check("rst enS", 64'(writeEnableScalar), 64'd0);
    check("rst enV", 64'(writeEnableVector), 64'd0);
    check("rst addr", 64'(writeAddress), 64'd0);
    check("rst sdata", 64'(writeScalarData), 64'd0);
    check("rst stall", 64'(stall), 64'd0);

    // Round robin with all three valid: grants 0,1,2,0,1,2.
    reset = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rr%0d ready", c), 64'(reqReady), 64'(3'b001 << (c % 3)));
      if (c > 0) check_write($sformatf("rr%0d wr", c), (c - 1) % 3);
      step();
    end
    check_write("rr6 wr", 2);
    reqValid = 3'b000;
    #1;
    check("idle ready", 64'(reqReady), 64'd0);
    step();
    check("idle enS", 64'(writeEnableScalar), 64'd0);
    check("idle enV", 64'(writeEnableVector), 64'd0);
    check("idle addr hold", 64'(writeAddress), 64'd10);

    // Vector write from requester 1, lanes 1..6 to v5.
    reqValid = 3'b010;
    reqAddress[1] = 4'd5;
    reqVectorData[1] = 48'h0605_0403_0201;
    #1;
    check("vec ready", 64'(reqReady), 64'b010);
    step();
    reqValid = 3'b000;
    check("vec enV", 64'(writeEnableVector), 64'd1);
    check("vec enS", 64'(writeEnableScalar), 64'd0);
    check("vec addr", 64'(writeAddress), 64'd5);
    check("vec data", 64'(writeVectorData), 64'h0000_0605_0403_0201);

    // RAW: issue scalar r3, then requester 0 writes r3.
    issueValid = 1'b1; issueIsVector = 1'b0; issueAddress = 4'd3;
    step();
    issueValid = 1'b0;
    check1Address = 4'd3;
    #1;
    check("raw s3 stall", 64'(stall), 64'd1);
    check1IsVector = 1'b1;
    #1;
    check("raw v3 nostall", 64'(stall), 64'd0);
    check1IsVector = 1'b0; check1Address = 4'd0; check2Address = 4'd3;
    #1;
    check("raw chk2 stall", 64'(stall), 64'd1);
    check2Address = 4'd0; checkDestAddress = 4'd3;
    #1;
    check("raw dest stall", 64'(stall), 64'd1);
    checkDestAddress = 4'd0; check1Address = 4'd3;
    reqValid = 3'b001; reqAddress[0] = 4'd3; reqScalarData[0] = 48'h0000_1234_5678;
    #1;
    check("raw ready", 64'(reqReady), 64'b001);
    check("raw pre stall", 64'(stall), 64'd1);
    step();
    reqValid = 3'b000;
    #1;
    check("raw wr enS", 64'(writeEnableScalar), 64'd1);
    check("raw wr addr", 64'(writeAddress), 64'd3);
    check("raw wr data", 64'(writeScalarData), 64'h0000_0000_1234_5678);
    check("raw wr stall", 64'(stall), 64'd1);
    step();
    check("raw cleared", 64'(stall), 64'd0);
    check("raw enS off", 64'(writeEnableScalar), 64'd0);

    // Same-cycle clear and re-issue of v7: set wins.
    issueValid = 1'b1; issueIsVector = 1'b1; issueAddress = 4'd7;
    step();
    issueValid = 1'b0;
    check1IsVector = 1'b1; check1Address = 4'd7;
    reqValid = 3'b010; reqAddress[1] = 4'd7;
    #1;
    check("sc v7 stall", 64'(stall), 64'd1);
    check("sc ready", 64'(reqReady), 64'b010);
    step();
    reqValid = 3'b000;
    issueValid = 1'b1; issueIsVector = 1'b1; issueAddress = 4'd7;
    #1;
    check("sc enV", 64'(writeEnableVector), 64'd1);
    check("sc addr", 64'(writeAddress), 64'd7);
    step();
    issueValid = 1'b0;
    #1;
    check("sc set wins", 64'(stall), 64'd1);
    step();
    check("sc still busy", 64'(stall), 64'd1);

    // Reset mid-flight: r2 busy and a transfer presented.
    issueValid = 1'b1; issueIsVector = 1'b0; issueAddress = 4'd2;
    step();
    issueValid = 1'b0;
    check1IsVector = 1'b0; check1Address = 4'd2;
    #1;
    check("mf r2 stall", 64'(stall), 64'd1);
    reqValid = 3'b001; reqAddress[0] = 4'd9;
    reset = 1'b0;
    #1;
    check("mf rst ready", 64'(reqReady), 64'd0);
    check("mf rst stall", 64'(stall), 64'd0);
    step();
    reset = 1'b1;
    reqValid = 3'b000;
    #1;
    check("mf enS", 64'(writeEnableScalar), 64'd0);
    check("mf enV", 64'(writeEnableVector), 64'd0);
    check("mf addr", 64'(writeAddress), 64'd0);
    check("mf r2 clear", 64'(stall), 64'd0);
    check1IsVector = 1'b1; check1Address = 4'd7;
    #1;
    check("mf v7 clear", 64'(stall), 64'd0);
    reqValid = 3'b111;
    #1;
    check("mf first grant", 64'(reqReady), 64'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
